// File: rtl/bus_master_port_if.sv
// Request/response and serial-bus signals of bus_master_port.
//   master : the view taken by bus_master_port itself (it drives ready,
//            the response, and tx; it receives the request, grant and rx).
//   slave  : the opposite view, for the user logic / bus model that
//            talks to the port.
// Widths follow ADDR_W / DATA_W and must match the port instance.
interface bus_master_port_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              grant;
    logic              tx;
    logic              rx;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, grant, rx,
        output req_ready, resp_valid, resp_rdata, resp_err, tx
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, grant, rx,
        input  req_ready, resp_valid, resp_rdata, resp_err, tx
    );
endinterface

// File: rtl/bus_master_port.sv
// Master-side serial bus port.
// Takes one read/write request from user logic, raises a start bit (tx=0)
// towards the arbiter, and once granted shifts out address (MSB first), a
// mode bit (1=write) and, for writes, the data byte. It then waits for the
// slave: a 0 on rx is the write acknowledge, or the start bit of read data,
// which is shifted in MSB first. Completion is a one-cycle resp_valid with
// resp_err set on grant timeout, grant loss or response timeout.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - bus_master_port_if.master (request, response, grant, tx, rx)
// All outputs, including tx, come straight from flops.
module bus_master_port #(
    parameter int ADDR_W        = 14,
    parameter int DATA_W        = 8,
    parameter int GRANT_TIMEOUT = 64,
    parameter int RESP_TIMEOUT  = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_master_port_if.master    bus
);

    localparam int MAX_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int BIT_W  = $clog2(MAX_W + 1);
    localparam int MAX_TO = (GRANT_TIMEOUT > RESP_TIMEOUT) ? GRANT_TIMEOUT : RESP_TIMEOUT;
    localparam int TO_W   = $clog2(MAX_TO + 1);

    localparam logic [BIT_W-1:0] ADDR_LAST  = BIT_W'(ADDR_W - 1);
    localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  GRANT_LAST = TO_W'(GRANT_TIMEOUT - 1);
    localparam logic [TO_W-1:0]  RESP_LAST  = TO_W'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, REQ, ADDR, MODE, DATA, WAIT_RSP, RDATA, DONE
    } state_t;

    state_t              state_q, state_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0]   data_sh_q, data_sh_d;
    logic [DATA_W-1:0]   rd_sh_q, rd_sh_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                tx_q, tx_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    // Completion request raised by any state; resolved once at the end.
    logic                finish;
    logic                finish_err;
    logic [DATA_W-1:0]   finish_rdata;

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_sh_d    = addr_sh_q;
        data_sh_d    = data_sh_q;
        rd_sh_d      = rd_sh_q;
        bit_cnt_d    = bit_cnt_q + BIT_W'(1);
        to_cnt_d     = (to_cnt_q == '1) ? to_cnt_q : to_cnt_q + TO_W'(1);
        tx_d         = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        req_ready_d  = 1'b0;
        finish       = 1'b0;
        finish_err   = 1'b0;
        finish_rdata = '0;

        // tx_d is the value the line shows in the *next* cycle, so each
        // branch picks the bit belonging to the state being entered.
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    we_d      = bus.req_we;
                    addr_sh_d = bus.req_addr;
                    data_sh_d = bus.req_wdata;
                    state_d   = REQ;
                    tx_d      = 1'b0;
                end
            end
            REQ: begin
                // A grant on the final allowed cycle still wins.
                if (bus.grant) begin
                    state_d = ADDR;
                    tx_d    = addr_sh_q[ADDR_W-1];
                end else if (to_cnt_q == GRANT_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else begin
                    tx_d = 1'b0;
                end
            end
            ADDR: begin
                if (!bus.grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bit_cnt_q == ADDR_LAST) begin
                    state_d = MODE;
                    tx_d    = we_q;
                end else begin
                    addr_sh_d = addr_sh_q << 1;
                    tx_d      = addr_sh_d[ADDR_W-1];
                end
            end
            MODE: begin
                if (!bus.grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (we_q) begin
                    state_d = DATA;
                    tx_d    = data_sh_q[DATA_W-1];
                end else begin
                    state_d = WAIT_RSP;
                end
            end
            DATA: begin
                if (!bus.grant) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end else if (bit_cnt_q == DATA_LAST) begin
                    state_d = WAIT_RSP;
                end else begin
                    data_sh_d = data_sh_q << 1;
                    tx_d      = data_sh_d[DATA_W-1];
                end
            end
            WAIT_RSP: begin
                // rx=0 is checked before the timeout so a response on the
                // last allowed cycle is still honoured.
                if (!bus.rx) begin
                    if (we_q) begin
                        finish = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (to_cnt_q == RESP_LAST) begin
                    finish     = 1'b1;
                    finish_err = 1'b1;
                end
            end
            RDATA: begin
                rd_sh_d = (rd_sh_q << 1) | DATA_W'(bus.rx);
                if (bit_cnt_q == DATA_LAST) begin
                    finish       = 1'b1;
                    finish_rdata = rd_sh_d;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (finish) begin
            state_d      = DONE;
            tx_d         = 1'b1;
            resp_valid_d = 1'b1;
            resp_err_d   = finish_err;
            resp_rdata_d = finish_rdata;
        end

        // Bit and timeout counters restart on every state change.
        if (state_d != state_q) begin
            bit_cnt_d = '0;
            to_cnt_d  = '0;
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            addr_sh_q    <= '0;
            data_sh_q    <= '0;
            rd_sh_q      <= '0;
            bit_cnt_q    <= '0;
            to_cnt_q     <= '0;
            tx_q         <= 1'b1;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_sh_q    <= addr_sh_d;
            data_sh_q    <= data_sh_d;
            rd_sh_q      <= rd_sh_d;
            bit_cnt_q    <= bit_cnt_d;
            to_cnt_q     <= to_cnt_d;
            tx_q         <= tx_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign bus.tx         = tx_q;
    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_bus_master_port.sv
// Bench for bus_master_port: a table of directed transactions with
// hand-computed completion cycle, error flag and read data, plus a
// hand-written reset-in-the-middle sequence. Cycle 0 of each transaction
// is the accept cycle; inputs for cycle c are driven 1 time unit after
// the edge that starts cycle c, and outputs are sampled at the same point.
module tb_bus_master_port;

    localparam int AW   = 14;
    localparam int DW   = 8;
    localparam int NONE = 100000;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bus_master_port_if #(.ADDR_W(AW), .DATA_W(DW)) bif ();

    bus_master_port #(
        .ADDR_W(AW), .DATA_W(DW), .GRANT_TIMEOUT(64), .RESP_TIMEOUT(256)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        int            grant_on;    // first cycle grant is high
        int            grant_drop;  // first cycle grant is low again
        int            ack_cyc;     // cycle the slave drives rx=0
        logic [DW-1:0] rd_val;      // read data sent after the start bit
        int            exp_cyc;     // cycle resp_valid is expected
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic rx_for(input vec_t v, input int c);
        int k;
        if (c == v.ack_cyc) return 1'b0;
        if (!v.we && c > v.ack_cyc && c <= v.ack_cyc + DW) begin
            k = DW - 1 - (c - v.ack_cyc - 1);
            return v.rd_val[k];
        end
        return 1'b1;
    endfunction

    // Runs one transaction starting in the current (idle) cycle and returns
    // what was observed; tx_bad is the first cycle whose tx disagreed with
    // the expected line, or -1.
    task automatic do_txn(input vec_t v, output int resp_cyc, output logic err,
                          output logic [DW-1:0] rdata, output int tx_bad,
                          output int busy_bad, output logic [31:0] ser);
        int s, n, nbits, c;
        logic got;
        logic exp_tx;
        logic [31:0] exp_bits;

        exp_bits = '0;
        for (int i = 0; i < AW; i++) exp_bits = {exp_bits[30:0], v.addr[AW-1-i]};
        exp_bits = {exp_bits[30:0], v.we};
        nbits = AW + 1;
        if (v.we) begin
            for (int i = 0; i < DW; i++) exp_bits = {exp_bits[30:0], v.wdata[DW-1-i]};
            nbits = nbits + DW;
        end
        s = ((v.grant_on < 1) ? 1 : v.grant_on) + 1;
        n = nbits;
        if (v.grant_drop - s + 1 < n) n = v.grant_drop - s + 1;
        if (n < 0) n = 0;

        bif.req_valid = 1'b1;
        bif.req_we    = v.we;
        bif.req_addr  = v.addr;
        bif.req_wdata = v.wdata;
        bif.grant     = (v.grant_on <= 0);
        bif.rx        = 1'b1;
        check("accept_ready", {31'b0, bif.req_ready}, 32'd1);
        step();

        c = 1; got = 1'b0; ser = '0; tx_bad = -1; busy_bad = 0;
        resp_cyc = -1; err = 1'bx; rdata = 'x;
        while (!got && c < 600) begin
            if (bif.resp_valid === 1'b1) begin
                got = 1'b1;
                resp_cyc = c;
                err = bif.resp_err;
                rdata = bif.resp_rdata;
                exp_tx = 1'b1;
            end else begin
                if (bif.req_ready !== 1'b0) busy_bad++;
                if (c < s) exp_tx = 1'b0;
                else if (c < s + n) exp_tx = exp_bits[nbits-1-(c-s)];
                else exp_tx = 1'b1;
            end
            if (bif.tx !== exp_tx && tx_bad < 0) tx_bad = c;
            if (c >= s && c < s + nbits) ser = {ser[30:0], bif.tx};
            if (!got) begin
                // Junk request while busy must be ignored.
                bif.req_valid = 1'b1;
                bif.req_we    = ~v.we;
                bif.req_addr  = ~v.addr;
                bif.req_wdata = ~v.wdata;
                bif.grant     = (c >= v.grant_on && c < v.grant_drop);
                bif.rx        = rx_for(v, c);
                step();
                c++;
            end
        end
        bif.req_valid = 1'b0;
        bif.grant     = 1'b0;
        bif.rx        = 1'b1;
    endtask

    task automatic run_vec(input int idx);
        int rc, txb, bb;
        logic e;
        logic [DW-1:0] rd;
        logic [31:0] ser;
        logic [31:0] lit;
        do_txn(vecs[idx], rc, e, rd, txb, bb, ser);
        $display("txn %0d: we=%0b addr=%h resp_cyc=%0d err=%0b rdata=%h",
                 idx, vecs[idx].we, vecs[idx].addr, rc, e, rd);
        check($sformatf("v%0d_resp_cyc", idx), rc, vecs[idx].exp_cyc);
        check($sformatf("v%0d_err", idx), {31'b0, e}, {31'b0, vecs[idx].exp_err});
        check($sformatf("v%0d_rdata", idx), {24'b0, rd}, {24'b0, vecs[idx].exp_rdata});
        check($sformatf("v%0d_tx_line_bad_cycle", idx), txb, -1);
        check($sformatf("v%0d_ready_while_busy", idx), bb, 0);
        if (idx == 0) begin
            lit = 32'b01101001011100_1_11000011;
            check("v0_serial_bits", ser, lit);
        end
        step();
        check($sformatf("v%0d_ready_after", idx), {31'b0, bif.req_ready}, 32'd1);
        check($sformatf("v%0d_valid_after", idx), {31'b0, bif.resp_valid}, 32'd0);
        check($sformatf("v%0d_err_hold", idx), {31'b0, bif.resp_err}, {31'b0, vecs[idx].exp_err});
        check($sformatf("v%0d_rdata_hold", idx), {24'b0, bif.resp_rdata}, {24'b0, vecs[idx].exp_rdata});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          we    addr      wdata  gon  gdrop ack   rd     cyc  err   rdata
        vecs[0]  = '{1'b1, 14'h1A5C, 8'hC3, 0,   NONE, 25,   8'h00, 26,  1'b0, 8'h00};
        vecs[1]  = '{1'b0, 14'h0003, 8'h00, 0,   NONE, 20,   8'h5A, 29,  1'b0, 8'h5A};
        vecs[2]  = '{1'b1, 14'h0100, 8'h11, NONE,NONE, NONE, 8'h00, 65,  1'b1, 8'h00};
        vecs[3]  = '{1'b1, 14'h3FFF, 8'hFF, 0,   7,    NONE, 8'h00, 8,   1'b1, 8'h00};
        vecs[4]  = '{1'b1, 14'h2222, 8'h44, 0,   NONE, NONE, 8'h00, 281, 1'b1, 8'h00};
        vecs[5]  = '{1'b0, 14'h1234, 8'h00, 0,   NONE, 17,   8'hA5, 26,  1'b0, 8'hA5};
        vecs[6]  = '{1'b1, 14'h0555, 8'h96, 5,   NONE, 29,   8'h00, 30,  1'b0, 8'h00};
        vecs[7]  = '{1'b1, 14'h0ABC, 8'h0F, 0,   16,   NONE, 8'h00, 17,  1'b1, 8'h00};
        vecs[8]  = '{1'b0, 14'h1111, 8'h00, 0,   NONE, NONE, 8'h00, 273, 1'b1, 8'h00};
        vecs[9]  = '{1'b0, 14'h2AAA, 8'h00, 64,  NONE, 80,   8'h3C, 89,  1'b0, 8'h3C};
        vecs[10] = '{1'b1, 14'h0001, 8'h80, 0,   24,   NONE, 8'h00, 25,  1'b1, 8'h00};
        vecs[11] = '{1'b1, 14'h3000, 8'h01, 0,   NONE, 280,  8'h00, 281, 1'b0, 8'h00};
        vecs[12] = '{1'b1, 14'h0F0F, 8'h5A, 0,   25,   27,   8'h00, 28,  1'b0, 8'h00};
        vecs[13] = '{1'b0, 14'h0000, 8'h00, 0,   NONE, 17,   8'hFF, 26,  1'b0, 8'hFF};

        rst = 1'b1;
        bif.req_valid = 1'b0;
        bif.req_we    = 1'b0;
        bif.req_addr  = '0;
        bif.req_wdata = '0;
        bif.grant     = 1'b0;
        bif.rx        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx", {31'b0, bif.tx}, 32'd1);
        check("rst_ready", {31'b0, bif.req_ready}, 32'd1);
        check("rst_valid", {31'b0, bif.resp_valid}, 32'd0);
        check("rst_err", {31'b0, bif.resp_err}, 32'd0);
        check("rst_rdata", {24'b0, bif.resp_rdata}, 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 14; i++) run_vec(i);

        // Reset asserted asynchronously in the middle of the DATA phase.
        bif.req_valid = 1'b1;
        bif.req_we    = 1'b1;
        bif.req_addr  = 14'h0F0F;
        bif.req_wdata = 8'h99;
        bif.grant     = 1'b1;
        bif.rx        = 1'b1;
        step();
        bif.req_valid = 1'b0;
        repeat (19) step();
        check("mid_data_tx_busy", {31'b0, bif.req_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        $display("txn rst: tx=%0b ready=%0b valid=%0b", bif.tx, bif.req_ready, bif.resp_valid);
        check("rst_mid_tx", {31'b0, bif.tx}, 32'd1);
        check("rst_mid_ready", {31'b0, bif.req_ready}, 32'd1);
        check("rst_mid_valid", {31'b0, bif.resp_valid}, 32'd0);
        step();
        rst = 1'b0;
        bif.grant = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("post_rst_valid_%0d", k), {31'b0, bif.resp_valid}, 32'd0);
            check($sformatf("post_rst_tx_%0d", k), {31'b0, bif.tx}, 32'd1);
        end
        run_vec(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_master_port.md
Name: bus_master_port

Overview:
- Master-side serial bus interface that sits directly upstream of the arbiter.
- Accepts one parallel read/write request from user logic through a valid/ready handshake.
- Issues a start bit to request the bus and waits for the arbiter grant. It then serializes address, mode and write data onto tx.
- Collects the slave acknowledge or read data from rx and returns a one-cycle response with an error flag.

Parameters:
ADDR_W, 14, address width; matches the address decoder's addr bus.
DATA_W, 8, data width of write and read payloads.
GRANT_TIMEOUT, 64, max cycles spent in REQ waiting for grant before abort.
RESP_TIMEOUT, 256, max cycles spent in WAIT_RSP waiting for ack or read start bit before abort.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
req_valid  input  1  user request valid.
req_ready  output  1  block idle; a request is accepted when req_valid and req_ready are both high.
req_we  input  1  1 = write, 0 = read.
req_addr  input  ADDR_W  target address.
req_wdata  input  DATA_W  write data; ignored for reads.
resp_valid  output  1  one-cycle pulse marking transaction completion.
resp_rdata  output  DATA_W  read data; valid with resp_valid on a successful read, 0 otherwise.
resp_err  output  1  valid with resp_valid; 1 = grant timeout, grant loss or response timeout.
grant  input  1  bus grant from arbiter for this master.
tx  output  1  serial line to bus; idle high.
rx  input  1  serial line from bus; idle high.

Behaviour:
- Reset values (async assert, sync release): tx=1, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0; state IDLE; counters cleared.
- Reset mid-transaction: abandon immediately, tx=1 in the same cycle, no resp_valid.
- States: IDLE, REQ, ADDR, MODE, DATA, WAIT_RSP, RDATA, DONE.
- IDLE:
  - req_ready=1, tx=1.
  - On accept, latch req_we, req_addr and req_wdata, then go to REQ.
  - Inputs are not sampled again until the next IDLE.
- REQ:
  - tx=0 (start bit), req_ready=0.
  - grant sampled high at a clock edge: go to ADDR.
  - After GRANT_TIMEOUT cycles in REQ without grant: go to DONE with err=1, tx=1.
- ADDR: one bit per cycle, MSB first, ADDR_W cycles.
- MODE: one cycle; tx = latched we.
- DATA (write only): DATA_W cycles, MSB first.
- Serialization exit: after the last serialized bit (MODE for reads, last DATA bit for writes), tx=1 and go to WAIT_RSP.
- Grant loss: grant sampled low in ADDR, MODE or DATA aborts to DONE with err=1, tx=1 the next cycle.
- WAIT_RSP:
  - Write: rx sampled 0 (ack) ends the wait and goes to DONE with err=0.
  - Read: rx sampled 0 is the start bit; go to RDATA.
  - After RESP_TIMEOUT cycles without rx=0: go to DONE with err=1.
  - grant is ignored in WAIT_RSP and RDATA.
- RDATA: shift rx in MSB first for exactly DATA_W cycles, then go to DONE.
- DONE:
  - resp_valid=1 for exactly one cycle; resp_err and resp_rdata valid.
  - resp_rdata=0 on error or write.
  - Next cycle IDLE, req_ready=1.
  - Outputs hold their values until the next DONE; only resp_valid returns to 0.
- Latency, write with grant present in the first REQ cycle and immediate ack:
  - accept at cycle 0; REQ cycle 1; ADDR cycles 2–15; MODE cycle 16; DATA cycles 17–24.
  - WAIT_RSP cycle 25 with rx=0; resp_valid at cycle 26.
- Latency, read with grant at cycle 1: MODE at cycle 16; earliest start bit at cycle 17; RDATA cycles 18–25; resp_valid at cycle 26.
- Timeout counters: saturating, cleared on every state entry, width sufficient for the larger timeout.
- req_valid while req_ready=0 has no effect; no queuing.

Test Plan:
- Write, addr=14'h1A5C, data=8'hC3, grant held high, rx=0 at cycle 25 → tx bits after the start bit are 01101001011100 then 1 then 11000011; resp_valid at cycle 26 with err=0.
- Read, addr=14'h0003, grant high, slave drives start bit at cycle 20 then 8'h5A MSB first → resp_valid one cycle after the last data bit, rdata=8'h5A, err=0.
- No grant for 64 cycles → tx returns to 1, resp_valid with err=1, rdata=0; req_ready=1 the following cycle.
- Grant dropped during address bit 5 → tx=1 the next cycle, resp_valid with err=1, no further bits driven.
- Write with rx held high for 256 cycles in WAIT_RSP → resp_err=1; a second back-to-back request is accepted the cycle after resp_valid.
- rst pulsed high mid-DATA → tx=1 and req_ready=1 immediately, no resp_valid; a subsequent write completes normally.
